// File: rtl/uart_alu_interface_if.sv
// Bundle between the byte-collecting FSM and its UART receiver/transmitter and ALU.
// The master side is the FSM; the slave side is the surrounding UART/ALU environment.
interface uart_alu_interface_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
);
  logic [NB_DATA-1:0] rx_data;
  logic               rx_done_tick;
  logic [NB_DATA-1:0] alu_result;
  logic               tx_done_tick;
  logic [NB_DATA-1:0] alu_a;
  logic [NB_DATA-1:0] alu_b;
  logic [NB_OP-1:0]   alu_op;
  logic [NB_DATA-1:0] tx_data;
  logic               tx_start;
  logic               busy;
  logic               overrun;

  modport master (
    input  rx_data, rx_done_tick, alu_result, tx_done_tick,
    output alu_a, alu_b, alu_op, tx_data, tx_start, busy, overrun
  );

  modport slave (
    output rx_data, rx_done_tick, alu_result, tx_done_tick,
    input  alu_a, alu_b, alu_op, tx_data, tx_start, busy, overrun
  );
endinterface

// File: rtl/uart_alu_interface.sv
// Collects A, B, opcode bytes from the UART, latches the ALU result and launches one tx frame;
// tx_start fires 2 cycles after the opcode tick; bytes arriving while busy are dropped with an overrun pulse.
module uart_alu_interface #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  uart_alu_interface_if.master  bus
);

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    CAPTURE,
    SEND,
    WAIT_TX
  } state_t;

  state_t             state;
  state_t             state_next;
  logic               load_a;
  logic               load_b;
  logic               load_op;
  logic               load_tx;
  logic               drop;

  logic [NB_DATA-1:0] alu_a_q;
  logic [NB_DATA-1:0] alu_b_q;
  logic [NB_OP-1:0]   alu_op_q;
  logic [NB_DATA-1:0] tx_data_q;
  logic               tx_start_q;
  logic               overrun_q;

  always_comb begin
    state_next = state;
    load_a     = 1'b0;
    load_b     = 1'b0;
    load_op    = 1'b0;
    load_tx    = 1'b0;
    drop       = 1'b0;
    case (state)
      WAIT_A: begin
        if (bus.rx_done_tick) begin
          load_a     = 1'b1;
          state_next = WAIT_B;
        end
      end
      WAIT_B: begin
        if (bus.rx_done_tick) begin
          load_b     = 1'b1;
          state_next = WAIT_OP;
        end
      end
      WAIT_OP: begin
        if (bus.rx_done_tick) begin
          load_op    = 1'b1;
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        load_tx    = 1'b1;
        drop       = bus.rx_done_tick;
        state_next = SEND;
      end
      SEND: begin
        drop       = bus.rx_done_tick;
        state_next = WAIT_TX;
      end
      WAIT_TX: begin
        // A byte landing on the same cycle as tx completion is still dropped.
        drop = bus.rx_done_tick;
        if (bus.tx_done_tick) begin
          state_next = WAIT_A;
        end
      end
      default: state_next = WAIT_A;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state      <= WAIT_A;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state <= state_next;
      if (load_a) begin
        alu_a_q <= bus.rx_data;
      end
      if (load_b) begin
        alu_b_q <= bus.rx_data;
      end
      if (load_op) begin
        alu_op_q <= bus.rx_data[NB_OP-1:0];
      end
      if (load_tx) begin
        tx_data_q <= bus.alu_result;
      end
      // Registered so the pulse coincides with the SEND state.
      tx_start_q <= (state_next == SEND);
      overrun_q  <= drop;
    end
  end

  assign bus.alu_a    = alu_a_q;
  assign bus.alu_b    = alu_b_q;
  assign bus.alu_op   = alu_op_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;
  assign bus.overrun  = overrun_q;
  assign bus.busy     = (state == CAPTURE) || (state == SEND) || (state == WAIT_TX);

endmodule

// File: tb/tb_uart_alu_interface.sv
// Randomized bench for uart_alu_interface: stimulus pushes expected frames into a queue,
// a negedge monitor pops and compares on every tx_start pulse.
module tb_uart_alu_interface;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_alu_interface_if #(.NB_DATA(8), .NB_OP(6)) bus ();

  uart_alu_interface #(.NB_DATA(8), .NB_OP(6)) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      default: return a;
    endcase
  endfunction

  assign bus.alu_result = alu_f(bus.alu_a, bus.alu_b, bus.alu_op);

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] res;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_fail = 0;
  int   exp_starts = 0;
  int   exp_ovr = 0;
  int   start_seen = 0;
  int   ovr_seen = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: compares every transmitted frame against the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.overrun === 1'b1) ovr_seen++;
      if (bus.tx_start === 1'b1) begin
        start_seen++;
        if (sb.size() == 0) begin
          check("unexpected_tx_start", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("tx_data", bus.tx_data, e.res);
          check("alu_a",   bus.alu_a,   e.a);
          check("alu_b",   bus.alu_b,   e.b);
          check("alu_op",  bus.alu_op,  e.op);
          check("tx_start_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rx_byte(input logic [7:0] b);
    bus.rx_data      = b;
    bus.rx_done_tick = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_done_tick = 1'b0;
  endtask

  // mode: 0 clean, 1 extra byte in CAPTURE, 2 extra byte in WAIT_TX, 3 extra byte with tx_done
  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb, input int mode);
    exp_t e;
    rx_byte(a);
    if ($urandom_range(0, 1) == 1) begin
      bus.tx_done_tick = 1'b1;
      idle(1);
      bus.tx_done_tick = 1'b0;
    end
    idle($urandom_range(0, 2));
    rx_byte(b);
    idle($urandom_range(0, 2));
    rx_byte(opb);
    e.a   = a;
    e.b   = b;
    e.op  = opb[5:0];
    e.res = alu_f(a, b, opb[5:0]);
    // The opcode tick was sampled at edge cyc; SEND occupies the cycle after the next edge.
    e.cyc = cyc + 1;
    sb.push_back(e);
    exp_starts++;
    if (mode == 1) begin
      rx_byte(8'($urandom));
      exp_ovr++;
      check("overrun_capture", bus.overrun, 1'b1);
    end else begin
      idle(1);
    end
    idle(1);
    check("busy_wait_tx", bus.busy, 1'b1);
    idle($urandom_range(0, 3));
    if (mode == 2) begin
      rx_byte(8'($urandom));
      exp_ovr++;
      check("overrun_wait_tx", bus.overrun, 1'b1);
      idle(1);
      check("overrun_single", bus.overrun, 1'b0);
      check("a_hold_overrun", bus.alu_a, a);
      check("b_hold_overrun", bus.alu_b, b);
      idle($urandom_range(0, 2));
    end
    bus.tx_done_tick = 1'b1;
    if (mode == 3) begin
      bus.rx_data      = 8'($urandom);
      bus.rx_done_tick = 1'b1;
      exp_ovr++;
    end
    idle(1);
    bus.tx_done_tick = 1'b0;
    bus.rx_done_tick = 1'b0;
    check("busy_after_tx", bus.busy, 1'b0);
    check("a_not_reloaded", bus.alu_a, a);
    check("tx_data_hold", bus.tx_data, e.res);
    if (mode == 3) check("overrun_simul", bus.overrun, 1'b1);
  endtask

  task automatic check_reset_zero(input string tag);
    check({tag, "_alu_a"},    bus.alu_a, 8'h00);
    check({tag, "_alu_b"},    bus.alu_b, 8'h00);
    check({tag, "_alu_op"},   bus.alu_op, 6'h00);
    check({tag, "_tx_data"},  bus.tx_data, 8'h00);
    check({tag, "_tx_start"}, bus.tx_start, 1'b0);
    check({tag, "_overrun"},  bus.overrun, 1'b0);
    check({tag, "_busy"},     bus.busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    n_fail++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] ops [6];
    logic [7:0] opb;
    logic [1:0] hi;
    ops[0] = 8'h20; ops[1] = 8'h22; ops[2] = 8'h24;
    ops[3] = 8'h25; ops[4] = 8'h26; ops[5] = 8'h27;

    rst_n            = 1'b0;
    bus.rx_data      = 8'h00;
    bus.rx_done_tick = 1'b0;
    bus.tx_done_tick = 1'b0;
    idle(3);
    check_reset_zero("reset");
    rst_n = 1'b1;

    run_txn(8'h05, 8'h03, 8'h20, 0);
    check("add_result", bus.tx_data, 8'h08);
    run_txn(8'h10, 8'h04, 8'hE2, 2);
    check("op_mask", bus.alu_op, 6'h22);
    run_txn(8'h33, 8'h0F, 8'h24, 3);
    run_txn(8'hA0, 8'h0A, 8'h25, 1);

    // Reset after two bytes must discard them.
    rx_byte(8'h11);
    rx_byte(8'h22);
    #2 rst_n = 1'b0;
    #1 check_reset_zero("mid_reset");
    idle(1);
    rst_n = 1'b1;
    run_txn(8'h01, 8'h02, 8'h24, 0);

    // Reset in CAPTURE must suppress the pending tx_start.
    rx_byte(8'h44);
    rx_byte(8'h55);
    rx_byte(8'h20);
    rst_n = 1'b0;
    #1 check_reset_zero("capture_reset");
    idle(1);
    rst_n = 1'b1;
    idle(4);
    check("no_start_after_reset", start_seen, exp_starts);

    for (int i = 0; i < 3; i++) begin
      run_txn(8'($urandom), 8'($urandom), 8'h26, 0);
    end

    for (int i = 0; i < 40; i++) begin
      hi  = 2'($urandom);
      opb = ops[$urandom_range(0, 5)];
      opb[7:6] = hi;
      run_txn(8'($urandom), 8'($urandom), opb, int'($urandom_range(0, 3)));
    end

    idle(5);
    check("sb_empty", sb.size(), 0);
    check("tx_start_count", start_seen, exp_starts);
    check("overrun_count", ovr_seen, exp_ovr);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
